// File: rtl/embedded_io_soc_pkg.sv
// Shared types and constants for the SoC-side embedded-I/O controller.
package embedded_io_soc_pkg;

  typedef enum logic [1:0] {
    ISOLATED = 2'd0,
    SETTLE   = 2'd1,
    ACTIVE   = 2'd2
  } iso_state_e;

  localparam int unsigned NUM_IO_DEFAULT        = 8;
  localparam int unsigned SYNC_STAGES_DEFAULT   = 2;
  localparam int unsigned SETTLE_CYCLES_DEFAULT = 16;

  localparam logic DIR_FABRIC_DRIVES = 1'b0;

endpackage

// File: rtl/io_sync_chain.sv
// Multi-flop synchroniser for asynchronous fabric signals; synchronous reset to RESET_VAL.
module io_sync_chain #(
  parameter int unsigned      WIDTH     = 1,
  parameter int unsigned      STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_chain [STAGES];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        r_chain[i] <= RESET_VAL;
      end
    end else begin
      r_chain[0] <= i_d;
      for (int i = 1; i < int'(STAGES); i++) begin
        r_chain[i] <= r_chain[i-1];
      end
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/embedded_io_soc_ctrl.sv
// SoC-side embedded-I/O controller: isolation sequencing, SOC_IN drive, qualified
// read-back of fabric outputs and sticky rising-edge interrupts.
module embedded_io_soc_ctrl
  import embedded_io_soc_pkg::*;
#(
  parameter int unsigned NUM_IO        = NUM_IO_DEFAULT,
  parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEFAULT,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
  input  logic              CK,
  input  logic              RSTN,
  input  logic              CONFIG_DONE,
  input  logic              ISOL_REQ,
  output logic              IO_ISOL_N,
  output logic [NUM_IO-1:0] SOC_IN,
  input  logic [NUM_IO-1:0] SOC_OUT,
  input  logic [NUM_IO-1:0] SOC_DIR,
  input  logic              WR_EN,
  input  logic [NUM_IO-1:0] WR_DATA,
  output logic [NUM_IO-1:0] RD_DATA,
  output logic [NUM_IO-1:0] RD_DIR,
  input  logic [NUM_IO-1:0] IRQ_MASK,
  input  logic [NUM_IO-1:0] IRQ_CLR,
  output logic [NUM_IO-1:0] IRQ_STATUS,
  output logic              IRQ,
  output logic [1:0]        STATE
);

  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE_CYCLES - 1);

  logic              w_cd_s;
  logic [NUM_IO-1:0] w_out_s;
  logic [NUM_IO-1:0] w_dir_s;

  io_sync_chain #(
    .WIDTH     (1),
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_sync_cd (
    .i_clk   (CK),
    .i_rst_n (RSTN),
    .i_d     (CONFIG_DONE),
    .o_q     (w_cd_s)
  );

  io_sync_chain #(
    .WIDTH     (NUM_IO),
    .STAGES    (SYNC_STAGES),
    .RESET_VAL ({NUM_IO{1'b0}})
  ) u_sync_out (
    .i_clk   (CK),
    .i_rst_n (RSTN),
    .i_d     (SOC_OUT),
    .o_q     (w_out_s)
  );

  // Direction resets to "not fabric-driven" so nothing qualifies before the fabric speaks.
  io_sync_chain #(
    .WIDTH     (NUM_IO),
    .STAGES    (SYNC_STAGES),
    .RESET_VAL ({NUM_IO{1'b1}})
  ) u_sync_dir (
    .i_clk   (CK),
    .i_rst_n (RSTN),
    .i_d     (SOC_DIR),
    .o_q     (w_dir_s)
  );

  iso_state_e        r_state, w_state_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic              r_isol_n;
  logic [NUM_IO-1:0] r_soc_in;
  logic [NUM_IO-1:0] r_rd_data, w_rd_data_d;
  logic [NUM_IO-1:0] r_rd_dir;
  logic [NUM_IO-1:0] r_valid, w_valid;
  logic [NUM_IO-1:0] r_status, w_status_d, w_set;
  logic              r_irq;
  logic              w_go_iso;

  // Isolation always wins over counting down or advancing.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_go_iso  = !w_cd_s || ISOL_REQ;
    unique case (r_state)
      ISOLATED: begin
        if (!w_go_iso) begin
          w_state_d = SETTLE;
          w_cnt_d   = CntLoad;
        end
      end
      SETTLE: begin
        if (w_go_iso) begin
          w_state_d = ISOLATED;
        end else if (r_cnt == '0) begin
          w_state_d = ACTIVE;
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      ACTIVE: begin
        if (w_go_iso) begin
          w_state_d = ISOLATED;
        end
      end
      default: w_state_d = ISOLATED;
    endcase
  end

  always_comb begin
    w_valid = '0;
    for (int i = 0; i < int'(NUM_IO); i++) begin
      w_valid[i] = (w_dir_s[i] == DIR_FABRIC_DRIVES) && (r_state == ACTIVE);
    end
    w_rd_data_d = (w_valid & w_out_s) | (~w_valid & r_rd_data);
    // Requiring valid in two consecutive cycles suppresses edges on entering valid.
    w_set       = r_valid & w_valid & w_out_s & ~r_rd_data & IRQ_MASK;
    w_status_d  = (r_status & ~IRQ_CLR) | w_set;
  end

  always_ff @(posedge CK) begin
    if (!RSTN) begin
      r_state   <= ISOLATED;
      r_cnt     <= '0;
      r_isol_n  <= 1'b0;
      r_soc_in  <= '0;
      r_rd_data <= '0;
      r_rd_dir  <= '1;
      r_valid   <= '0;
      r_status  <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_isol_n  <= (w_state_d == ACTIVE);
      if (WR_EN) begin
        r_soc_in <= WR_DATA;
      end
      r_rd_data <= w_rd_data_d;
      r_rd_dir  <= w_dir_s;
      r_valid   <= w_valid;
      r_status  <= w_status_d;
      r_irq     <= |r_status;
    end
  end

  assign IO_ISOL_N  = r_isol_n;
  assign SOC_IN     = r_soc_in;
  assign RD_DATA    = r_rd_data;
  assign RD_DIR     = r_rd_dir;
  assign IRQ_STATUS = r_status;
  assign IRQ        = r_irq;
  assign STATE      = r_state;

endmodule

// File: tb/tb_embedded_io_soc_ctrl.sv
// Directed plus randomized bench for embedded_io_soc_ctrl against a behavioural reference.
module tb_embedded_io_soc_ctrl;

  localparam int N      = 8;
  localparam int SYNC   = 2;
  localparam int SETTLE = 4;

  logic         CK = 1'b0;
  logic         RSTN, CONFIG_DONE, ISOL_REQ, WR_EN;
  logic [N-1:0] SOC_OUT, SOC_DIR, WR_DATA, IRQ_MASK, IRQ_CLR;
  logic         IO_ISOL_N, IRQ;
  logic [N-1:0] SOC_IN, RD_DATA, RD_DIR, IRQ_STATUS;
  logic [1:0]   STATE;

  int n_chk = 0;
  int n_err = 0;

  embedded_io_soc_ctrl #(
    .NUM_IO        (N),
    .SYNC_STAGES   (SYNC),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .CK          (CK),
    .RSTN        (RSTN),
    .CONFIG_DONE (CONFIG_DONE),
    .ISOL_REQ    (ISOL_REQ),
    .IO_ISOL_N   (IO_ISOL_N),
    .SOC_IN      (SOC_IN),
    .SOC_OUT     (SOC_OUT),
    .SOC_DIR     (SOC_DIR),
    .WR_EN       (WR_EN),
    .WR_DATA     (WR_DATA),
    .RD_DATA     (RD_DATA),
    .RD_DIR      (RD_DIR),
    .IRQ_MASK    (IRQ_MASK),
    .IRQ_CLR     (IRQ_CLR),
    .IRQ_STATUS  (IRQ_STATUS),
    .IRQ         (IRQ),
    .STATE       (STATE)
  );

  always #5 CK = ~CK;

  // Reference: synchronisers are pure delays (last SYNC samples), the isolation
  // sequencer is a phase number plus a count of remaining settle cycles.
  bit           q_cd[$];
  logic [N-1:0] q_out[$];
  logic [N-1:0] q_dir[$];
  int           m_phase, m_left;
  logic         m_isol_n, m_irq;
  logic [N-1:0] m_soc_in, m_rd, m_rd_dir, m_status, m_valid_prev;

  task automatic model_reset();
    q_cd.delete(); q_out.delete(); q_dir.delete();
    for (int i = 0; i < SYNC; i++) begin
      q_cd.push_back(1'b0); q_out.push_back('0); q_dir.push_back('1);
    end
    m_phase = 0; m_left = 0; m_isol_n = 0; m_irq = 0;
    m_soc_in = '0; m_rd = '0; m_rd_dir = '1; m_status = '0; m_valid_prev = '0;
  endtask

  task automatic model_edge();
    bit           cd_s;
    logic [N-1:0] out_s, dir_s, valid, rise;
    if (!RSTN) begin
      model_reset();
      return;
    end
    cd_s  = q_cd[0];
    out_s = q_out[0];
    dir_s = q_dir[0];
    valid = (m_phase == 2) ? ~dir_s : '0;
    rise  = valid & m_valid_prev & out_s & ~m_rd & IRQ_MASK;
    m_irq    = (m_status != 0);
    m_status = (m_status & ~IRQ_CLR) | rise;
    for (int i = 0; i < N; i++) if (valid[i]) m_rd[i] = out_s[i];
    m_valid_prev = valid;
    m_rd_dir     = dir_s;
    if (WR_EN) m_soc_in = WR_DATA;
    if (!cd_s || ISOL_REQ) begin
      m_phase = 0;
    end else if (m_phase == 0) begin
      m_phase = 1;
      m_left  = SETTLE - 1;
    end else if (m_phase == 1) begin
      if (m_left == 0) m_phase = 2;
      else m_left--;
    end
    m_isol_n = (m_phase == 2);
    q_cd.push_back(CONFIG_DONE);  void'(q_cd.pop_front());
    q_out.push_back(SOC_OUT);     void'(q_out.pop_front());
    q_dir.push_back(SOC_DIR);     void'(q_dir.pop_front());
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    chk("model.STATE",      32'(STATE),      32'(m_phase));
    chk("model.IO_ISOL_N",  32'(IO_ISOL_N),  32'(m_isol_n));
    chk("model.SOC_IN",     32'(SOC_IN),     32'(m_soc_in));
    chk("model.RD_DATA",    32'(RD_DATA),    32'(m_rd));
    chk("model.RD_DIR",     32'(RD_DIR),     32'(m_rd_dir));
    chk("model.IRQ_STATUS", 32'(IRQ_STATUS), 32'(m_status));
    chk("model.IRQ",        32'(IRQ),        32'(m_irq));
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      model_edge();
      @(posedge CK);
      #1;
      check_model();
    end
  endtask

  initial begin
    RSTN = 0; CONFIG_DONE = 0; ISOL_REQ = 0; WR_EN = 0;
    SOC_OUT = '0; SOC_DIR = '1; WR_DATA = '0; IRQ_MASK = '0; IRQ_CLR = '0;
    model_reset();
    tick(2);
    chk("rst.STATE", 32'(STATE), 32'd0);
    chk("rst.RD_DIR", 32'(RD_DIR), 32'hFF);
    chk("rst.IO_ISOL_N", 32'(IO_ISOL_N), 32'd0);

    // Bring-up: SETTLE 3 edges after CONFIG_DONE, ACTIVE 4 edges after that
    RSTN = 1; SOC_DIR = 8'h00;
    tick(2);
    CONFIG_DONE = 1;
    tick(2);
    chk("up.still_iso", 32'(STATE), 32'd0);
    tick(1);
    chk("up.settle", 32'(STATE), 32'd1);
    tick(3);
    chk("up.settle_hold", 32'(STATE), 32'd1);
    chk("up.isol_low", 32'(IO_ISOL_N), 32'd0);
    tick(1);
    chk("up.active", 32'(STATE), 32'd2);
    chk("up.isol_high", 32'(IO_ISOL_N), 32'd1);
    tick(1);

    // Rising edges on bits 0 and 2, only bit 0 unmasked
    IRQ_MASK = 8'h01; SOC_OUT = 8'h05;
    tick(2);
    chk("edge.rd_before", 32'(RD_DATA), 32'h00);
    tick(1);
    chk("edge.rd", 32'(RD_DATA), 32'h05);
    chk("edge.status", 32'(IRQ_STATUS), 32'h01);
    chk("edge.irq_lag", 32'(IRQ), 32'd0);
    tick(1);
    chk("edge.irq", 32'(IRQ), 32'd1);

    // Clear coinciding with a new edge loses; clear alone wins
    SOC_OUT = 8'h04;
    tick(3);
    SOC_OUT = 8'h05;
    tick(2);
    IRQ_CLR = 8'h01;
    tick(1);
    chk("clr.set_wins", 32'(IRQ_STATUS), 32'h01);
    IRQ_CLR = 8'h00;
    tick(1);
    IRQ_CLR = 8'h01;
    tick(1);
    chk("clr.cleared", 32'(IRQ_STATUS), 32'h00);
    IRQ_CLR = 8'h00;
    tick(1);
    chk("clr.irq_low", 32'(IRQ), 32'd0);

    // Direction flip into valid never raises an edge; leaving valid holds RD_DATA
    IRQ_MASK = 8'hFF; SOC_DIR = 8'h08; SOC_OUT = 8'h0D;
    tick(4);
    chk("dir.hold_in", 32'(RD_DATA), 32'h05);
    SOC_DIR = 8'h00;
    tick(4);
    chk("dir.enter_rd", 32'(RD_DATA), 32'h0D);
    chk("dir.no_irq", 32'(IRQ_STATUS), 32'h00);
    SOC_DIR = 8'h08;
    tick(3);
    SOC_OUT = 8'h05;
    tick(4);
    chk("dir.hold_out", 32'(RD_DATA), 32'h0D);

    // Drop CONFIG_DONE mid-SETTLE: isolation beats advancing, then full recount
    ISOL_REQ = 1;
    tick(1);
    chk("iso.req", 32'(STATE), 32'd0);
    ISOL_REQ = 0;
    tick(2);
    CONFIG_DONE = 0;
    tick(2);
    chk("iso.settle_cnt0", 32'(STATE), 32'd1);
    tick(1);
    chk("iso.dropped", 32'(STATE), 32'd0);
    chk("iso.isol_low", 32'(IO_ISOL_N), 32'd0);
    CONFIG_DONE = 1;
    tick(3);
    chk("iso.resettle", 32'(STATE), 32'd1);
    tick(3);
    chk("iso.recount", 32'(STATE), 32'd1);
    tick(1);
    chk("iso.reactive", 32'(STATE), 32'd2);

    // SOC_IN written during isolation survives until a mid-ACTIVE reset
    ISOL_REQ = 1;
    tick(1);
    WR_EN = 1; WR_DATA = 8'hA5;
    tick(1);
    WR_EN = 0; ISOL_REQ = 0;
    chk("wr.iso", 32'(SOC_IN), 32'hA5);
    tick(5);
    chk("wr.active", 32'(STATE), 32'd2);
    chk("wr.kept", 32'(SOC_IN), 32'hA5);
    RSTN = 0;
    tick(1);
    chk("wr.rst_socin", 32'(SOC_IN), 32'h00);
    chk("wr.rst_dir", 32'(RD_DIR), 32'hFF);
    chk("wr.rst_state", 32'(STATE), 32'd0);
    RSTN = 1;
    tick(1);

    // Randomized traffic against the reference
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 39) == 0) CONFIG_DONE = ~CONFIG_DONE;
      if (!ISOL_REQ) ISOL_REQ = ($urandom_range(0, 49) == 0);
      else ISOL_REQ = ($urandom_range(0, 3) != 0);
      RSTN = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 1) == 0) SOC_OUT = N'($urandom);
      if ($urandom_range(0, 7) == 0) SOC_DIR = N'($urandom) & N'($urandom);
      if ($urandom_range(0, 15) == 0) IRQ_MASK = N'($urandom);
      IRQ_CLR = N'($urandom) & N'($urandom) & N'($urandom);
      WR_EN = ($urandom_range(0, 3) == 0);
      WR_DATA = N'($urandom);
      tick(1);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/embedded_io_soc_ctrl.md
Name: embedded_io_soc_ctrl

Overview:
SoC-side counterpart of the FPGA embedded-I/O overlay with active-low isolation. It drives SOC_IN toward the fabric and synchronises the fabric's SOC_OUT/SOC_DIR into the SoC clock domain. It sequences the IO_ISOL_N release after configuration completes and raises per-bit rising-edge interrupts on fabric outputs. It sits in the SoC wrapper between the FPGA top-level I/O bus and a simple register interface.

Parameters:
NUM_IO, 8, number of embedded I/Os handled
SYNC_STAGES, 2, flops in each CDC synchroniser (legal values are 2 or more)
SETTLE_CYCLES, 16, cycles held in SETTLE before IO_ISOL_N is released (legal values are 1 or more)

Ports:
CK  input  1  SoC clock
RSTN  input  1  synchronous active-low reset
CONFIG_DONE  input  1  fabric configuration-complete flag; asynchronous, synchronised internally
ISOL_REQ  input  1  software force-isolate, level-sensitive
IO_ISOL_N  output  1  active-low isolation enable to all embedded I/Os
SOC_IN  output  NUM_IO  data driven into the fabric
SOC_OUT  input  NUM_IO  data from the fabric; asynchronous
SOC_DIR  input  NUM_IO  fabric direction; 0 = fabric drives SOC_OUT; asynchronous
WR_EN  input  1  load WR_DATA into the SOC_IN register
WR_DATA  input  NUM_IO  new SOC_IN value
RD_DATA  output  NUM_IO  qualified, synchronised SOC_OUT
RD_DIR  output  NUM_IO  synchronised SOC_DIR
IRQ_MASK  input  NUM_IO  1 = rising edge on the bit sets its status
IRQ_CLR  input  NUM_IO  write-1-to-clear for IRQ_STATUS
IRQ_STATUS  output  NUM_IO  sticky edge flags
IRQ  output  1  OR-reduction of IRQ_STATUS
STATE  output  2  isolation FSM state

Behaviour:
- Reset values when RSTN=0 at a CK edge: IO_ISOL_N=0, SOC_IN=0, RD_DATA=0, RD_DIR=all 1, IRQ_STATUS=0, IRQ=0, STATE=ISOLATED, settle counter=0, all synchroniser flops=0 except the SOC_DIR chain, which resets to 1.
- Reset is honoured mid-operation in any state. All outputs take their reset values at that edge.
- Synchronisers: CONFIG_DONE, SOC_OUT and SOC_DIR each pass through a SYNC_STAGES-deep flop chain. The synchronised values are cd_s, out_s and dir_s.
- FSM state encodings: ISOLATED=0, SETTLE=1, ACTIVE=2.
  - ISOLATED: IO_ISOL_N=0. Move to SETTLE when cd_s=1 and ISOL_REQ=0; the counter loads SETTLE_CYCLES-1.
  - SETTLE: IO_ISOL_N=0. The counter decrements each cycle. Move to ACTIVE on the cycle the counter equals 0.
  - ACTIVE: IO_ISOL_N=1.
  - From SETTLE or ACTIVE, return to ISOLATED when cd_s=0 or ISOL_REQ=1. IO_ISOL_N falls on the next edge. Isolation takes priority over advancing the counter.
  - IO_ISOL_N is registered and equals 1 only when STATE=ACTIVE.
- SOC_IN: registered. WR_EN=1 loads WR_DATA at the edge; the new value appears on SOC_IN the next cycle. The register is independent of the FSM, so writes during isolation are retained.
- Qualification: bit i is valid when dir_s[i]=0 and STATE=ACTIVE.
  - When valid, RD_DATA[i] takes out_s[i] at each edge.
  - When not valid, RD_DATA[i] holds its value.
  - RD_DIR is the registered copy of dir_s.
- Latency: a SOC_OUT change reaches RD_DATA after SYNC_STAGES+1 edges.
- Edge detect: bit i sets IRQ_STATUS[i] when all of the following hold:
  - bit i was valid in both the previous and the current cycle (a per-bit valid_q register tracks the previous cycle);
  - out_s[i]=1 and RD_DATA[i]=0;
  - IRQ_MASK[i]=1.
  The flag sets in the same cycle RD_DATA[i] rises.
- Because of the double-valid rule, entering valid (a direction flip or leaving isolation) never generates an edge.
- IRQ_CLR[i]=1 clears IRQ_STATUS[i]. If a set and a clear occur in the same cycle, the set wins.
- Masking a bit does not clear an already-set flag.
- IRQ is registered: it equals |IRQ_STATUS one cycle after IRQ_STATUS changes.

Decomposition:
- Package embedded_io_soc_pkg holds the state typedef (ISOLATED/SETTLE/ACTIVE with the encodings above), the default parameter constants, and the direction constant DIR_FABRIC_DRIVES=0.
- One sub-module, io_sync_chain (parameters WIDTH, STAGES, RESET_VAL), is instantiated for CONFIG_DONE, SOC_OUT and SOC_DIR.

Test Plan:
1. Reset then CONFIG_DONE=1 (NUM_IO=8, SYNC=2, SETTLE=4) -> STATE reaches SETTLE 3 edges after CONFIG_DONE rises, ACTIVE 4 edges later, and IO_ISOL_N=1 in that same cycle; IO_ISOL_N is 0 throughout before that.
2. ACTIVE, SOC_DIR=8'h00, SOC_OUT 8'h00->8'h05, IRQ_MASK=8'h01 -> RD_DATA=8'h05 after 3 edges, IRQ_STATUS=8'h01, IRQ=1 one edge later; bit 2 does not set.
3. IRQ_STATUS=8'h01 held, then IRQ_CLR=8'h01 in the same cycle as a new bit-0 rising edge -> IRQ_STATUS stays 8'h01. Then IRQ_CLR=8'h01 alone -> IRQ_STATUS=0 and IRQ=0 one edge later.
4. ACTIVE with SOC_OUT[3]=1 held, SOC_DIR[3] 1->0 -> RD_DATA[3]=1 with no IRQ_STATUS[3] set. SOC_DIR[3] 0->1 then SOC_OUT[3]=0 -> RD_DATA[3] stays 1.
5. In SETTLE with counter=2, CONFIG_DONE dropped (or ISOL_REQ=1) -> STATE=ISOLATED and IO_ISOL_N stays 0; a later release restarts the full SETTLE_CYCLES count.
6. WR_EN=1, WR_DATA=8'hA5 during ISOLATED, then RSTN=0 for one edge while in ACTIVE -> SOC_IN=8'hA5 until the reset edge, then SOC_IN=0, RD_DIR=8'hFF, STATE=ISOLATED.
